// File: rtl/chip_test_sequencer_if.sv
//------------------------------------------------------------------------------
// Module      : chip_test_sequencer_if
// Description : Front-panel and tester handshake bundle for chip_test_sequencer.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

interface chip_test_sequencer_if;
    logic       Start;
    logic       Done;
    logic       RSLT;
    logic       Run;
    logic       DISP_RSLT;
    logic       Busy;
    logic       Pass;
    logic       Fail;
    logic       Timeout;
    logic [2:0] StateCode;

    modport master (
        output Start, Done, RSLT,
        input  Run, DISP_RSLT, Busy, Pass, Fail, Timeout, StateCode
    );

    modport slave (
        input  Start, Done, RSLT,
        output Run, DISP_RSLT, Busy, Pass, Fail, Timeout, StateCode
    );
endinterface

`default_nettype wire

// File: rtl/chip_test_sequencer.sv
//------------------------------------------------------------------------------
// Module      : chip_test_sequencer
// Description : Debounces Start, launches the tester, captures/holds the
//               verdict with a Done timeout, then releases the tester.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module chip_test_sequencer #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int TIMEOUT_CYCLES  = 1024,
    parameter int HOLD_CYCLES     = 64
) (
    input wire                   Clk,
    input wire                   Reset,
    chip_test_sequencer_if.slave bus
);

    localparam int c_MAX_AB    = (DEBOUNCE_CYCLES > TIMEOUT_CYCLES) ? DEBOUNCE_CYCLES : TIMEOUT_CYCLES;
    localparam int c_MAX_PARAM = (c_MAX_AB > HOLD_CYCLES) ? c_MAX_AB : HOLD_CYCLES;
    localparam int c_CNT_W     = $clog2(c_MAX_PARAM) + 1;
    localparam int c_DB_W      = $clog2(DEBOUNCE_CYCLES) + 1;

    localparam logic [c_CNT_W-1:0] c_TO_LAST   = c_CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_HOLD_LAST = c_CNT_W'(HOLD_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX   = {c_CNT_W{1'b1}};
    localparam logic [c_DB_W-1:0]  c_DB_LAST   = c_DB_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LAUNCH    = 3'd1,
        S_WAIT_DONE = 3'd2,
        S_CAPTURE   = 3'd3,
        S_HOLD      = 3'd4,
        S_RELEASE   = 3'd5
    } state_t;

    logic              r_sync1;
    logic              r_sync2;
    logic              r_db_level;
    logic              r_db_prev;
    logic [c_DB_W-1:0] r_db_cnt;
    logic              w_start_evt;

    state_t             r_state;
    state_t             w_state_next;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_CNT_W-1:0] w_cnt_next;
    logic [c_CNT_W-1:0] w_cnt_inc;
    logic               r_pass;
    logic               r_fail;
    logic               r_timeout;
    logic               w_pass_next;
    logic               w_fail_next;
    logic               w_timeout_next;

    // The debounced level only follows the synchronized input after it has
    // disagreed for DEBOUNCE_CYCLES consecutive cycles; any agreement restarts.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_sync1    <= 1'b0;
            r_sync2    <= 1'b0;
            r_db_level <= 1'b0;
            r_db_prev  <= 1'b0;
            r_db_cnt   <= '0;
        end else begin
            r_sync1   <= bus.Start;
            r_sync2   <= r_sync1;
            r_db_prev <= r_db_level;
            if (r_sync2 != r_db_level) begin
                if (r_db_cnt == c_DB_LAST) begin
                    r_db_level <= r_sync2;
                    r_db_cnt   <= '0;
                end else begin
                    r_db_cnt <= r_db_cnt + 1'b1;
                end
            end else begin
                r_db_cnt <= '0;
            end
        end
    end

    assign w_start_evt = r_db_level & ~r_db_prev;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_pass    <= 1'b0;
            r_fail    <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_cnt     <= w_cnt_next;
            r_pass    <= w_pass_next;
            r_fail    <= w_fail_next;
            r_timeout <= w_timeout_next;
        end
    end

    assign w_cnt_inc = (r_cnt == c_CNT_MAX) ? r_cnt : r_cnt + 1'b1;

    always_comb begin
        w_state_next   = r_state;
        w_cnt_next     = r_cnt;
        w_pass_next    = r_pass;
        w_fail_next    = r_fail;
        w_timeout_next = r_timeout;
        case (r_state)
            S_IDLE: begin
                if (w_start_evt) begin
                    w_pass_next    = 1'b0;
                    w_fail_next    = 1'b0;
                    w_timeout_next = 1'b0;
                    w_state_next   = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                w_cnt_next   = '0;
                w_state_next = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                w_cnt_next = w_cnt_inc;
                // Done wins when it coincides with the final timeout cycle.
                if (bus.Done) begin
                    w_state_next = S_CAPTURE;
                end else if (r_cnt == c_TO_LAST) begin
                    w_pass_next    = 1'b0;
                    w_fail_next    = 1'b1;
                    w_timeout_next = 1'b1;
                    w_cnt_next     = '0;
                    w_state_next   = S_HOLD;
                end
            end
            S_CAPTURE: begin
                w_pass_next  = bus.RSLT;
                w_fail_next  = ~bus.RSLT;
                w_cnt_next   = '0;
                w_state_next = S_HOLD;
            end
            S_HOLD: begin
                w_cnt_next = w_cnt_inc;
                if (r_cnt == c_HOLD_LAST) begin
                    w_state_next = S_RELEASE;
                end
            end
            S_RELEASE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    assign bus.Run       = (r_state == S_LAUNCH);
    assign bus.DISP_RSLT = (r_state == S_RELEASE);
    assign bus.Busy      = (r_state != S_IDLE);
    assign bus.Pass      = r_pass;
    assign bus.Fail      = r_fail;
    assign bus.Timeout   = r_timeout;
    assign bus.StateCode = r_state;

endmodule

`default_nettype wire
